// File: rtl/tetris_pkg.sv
// Shared Tetris playfield definitions used by the board store and the display renderer.
package tetris_pkg;

    localparam int BOARD_W = 10;
    localparam int BOARD_H = 20;
    localparam int KIND_W  = 4;

    typedef logic [KIND_W-1:0] kind_t;

    localparam kind_t KIND_EMPTY = '0;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } board_state_t;

endpackage

// File: rtl/tetris_board_if.sv
// Renderer lookup, piece-lock write and line-clear control bundle of the playfield store.
interface tetris_board_if #(
    parameter int KIND_W = tetris_pkg::KIND_W
);

    logic [4:0]        rd_x;
    logic [4:0]        rd_y;
    logic [KIND_W-1:0] rd_kind;
    logic              wr_en;
    logic [4:0]        wr_x;
    logic [4:0]        wr_y;
    logic [KIND_W-1:0] wr_kind;
    logic              clear_start;
    logic              clear_board;
    logic              busy;
    logic              clear_done;
    logic [2:0]        lines_cleared;

    // Master is the game/renderer side, slave is the board itself.
    modport master (
        output rd_x, rd_y, wr_en, wr_x, wr_y, wr_kind, clear_start, clear_board,
        input  rd_kind, busy, clear_done, lines_cleared
    );

    modport slave (
        input  rd_x, rd_y, wr_en, wr_x, wr_y, wr_kind, clear_start, clear_board,
        output rd_kind, busy, clear_done, lines_cleared
    );

endinterface

// File: rtl/tetris_row_full.sv
// Combinational full-row test: high when every cell of the packed row is non-empty.
module tetris_row_full #(
    parameter int WIDTH  = tetris_pkg::BOARD_W,
    parameter int KIND_W = tetris_pkg::KIND_W
) (
    input  logic [WIDTH*KIND_W-1:0] row,
    output logic                    full
);

    logic [WIDTH-1:0] occupied;

    always_comb begin
        occupied = '0;
        for (int i = 0; i < WIDTH; i++) begin
            occupied[i] = |row[i*KIND_W +: KIND_W];
        end
    end

    assign full = &occupied;

endmodule

// File: rtl/tetris_board.sv
// Playfield store with registered renderer lookups, piece-lock writes and a
// bottom-up line-clear engine that removes full rows and drops the rows above.
module tetris_board #(
    parameter int WIDTH  = tetris_pkg::BOARD_W,
    parameter int HEIGHT = tetris_pkg::BOARD_H,
    parameter int KIND_W = tetris_pkg::KIND_W
) (
    input  logic          clk,
    input  logic          reset_n,
    tetris_board_if.slave bus
);

    import tetris_pkg::*;

    localparam int XW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

    logic [WIDTH-1:0][KIND_W-1:0] rows [HEIGHT];

    board_state_t      state;
    logic [YW-1:0]     r;
    logic [2:0]        cnt;
    logic              row_full;
    logic              rd_hit;
    logic              wr_hit;
    logic [KIND_W-1:0] rd_kind_q;
    logic              busy_q;
    logic              done_q;
    logic [2:0]        lines_q;

    assign rd_hit = (bus.rd_x < 5'(WIDTH)) && (bus.rd_y < 5'(HEIGHT));
    assign wr_hit = bus.wr_en && (bus.wr_x < 5'(WIDTH)) && (bus.wr_y < 5'(HEIGHT));

    tetris_row_full #(
        .WIDTH  (WIDTH),
        .KIND_W (KIND_W)
    ) u_row_full (
        .row  (rows[r]),
        .full (row_full)
    );

    assign bus.rd_kind       = rd_kind_q;
    assign bus.busy          = busy_q;
    assign bus.clear_done    = done_q;
    assign bus.lines_cleared = lines_q;

    // The lookup samples the array before this edge's updates, so a same-cell
    // write is seen one cycle later; clear_board outranks every other action.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < HEIGHT; i++) begin
                rows[i] <= '0;
            end
            state     <= IDLE;
            r         <= '0;
            cnt       <= '0;
            rd_kind_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            lines_q   <= '0;
        end else begin
            rd_kind_q <= rd_hit ? rows[bus.rd_y[YW-1:0]][bus.rd_x[XW-1:0]] : '0;

            if (bus.clear_board) begin
                for (int i = 0; i < HEIGHT; i++) begin
                    rows[i] <= '0;
                end
                state  <= IDLE;
                r      <= '0;
                cnt    <= '0;
                busy_q <= 1'b0;
                done_q <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (wr_hit) begin
                            rows[bus.wr_y[YW-1:0]][bus.wr_x[XW-1:0]] <= bus.wr_kind;
                        end
                        if (bus.clear_start) begin
                            state   <= SCAN;
                            r       <= YW'(HEIGHT - 1);
                            cnt     <= '0;
                            lines_q <= '0;
                            busy_q  <= 1'b1;
                        end
                    end

                    // A full row is collapsed in one cycle and r holds, so the
                    // row that just dropped into place gets tested next.
                    SCAN: begin
                        if (row_full) begin
                            for (int i = 1; i < HEIGHT; i++) begin
                                if (i <= int'(r)) begin
                                    rows[i] <= rows[i-1];
                                end
                            end
                            rows[0] <= '0;
                            if (cnt != 3'd7) begin
                                cnt <= cnt + 3'd1;
                            end
                        end else if (r == '0) begin
                            state   <= DONE;
                            lines_q <= cnt;
                            done_q  <= 1'b1;
                        end else begin
                            r <= r - 1'b1;
                        end
                    end

                    DONE: begin
                        state  <= IDLE;
                        done_q <= 1'b0;
                        busy_q <= 1'b0;
                    end

                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tetris_board.sv
// Self-checking bench for tetris_board: table-driven cell accesses with a read
// scoreboard, then multi-cycle line-clear, busy, clear_board and reset sequences.
module tb_tetris_board;

    import tetris_pkg::*;

    localparam int W = BOARD_W;
    localparam int H = BOARD_H;

    typedef struct {
        logic we;
        int   wx;
        int   wy;
        int   wk;
        logic re;
        int   rx;
        int   ry;
        int   exp;
    } vec_t;

    typedef struct {
        int exp;
        int x;
        int y;
    } rd_exp_t;

    logic    clk = 1'b0;
    logic    reset_n = 1'b1;
    logic    rd_req = 1'b0;
    int      tests_run = 0;
    int      tests_failed = 0;
    int      model [H][W];
    rd_exp_t sb_q [$];
    vec_t    vecs [14];

    tetris_board_if #(.KIND_W(KIND_W)) bus();

    tetris_board #(
        .WIDTH  (W),
        .HEIGHT (H),
        .KIND_W (KIND_W)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        tests_run++;
        if (actual != expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Every read issued one edge earlier is checked against the oldest queued expectation.
    always @(posedge clk) begin : rd_monitor
        rd_exp_t e;
        if (rd_req) begin
            #1;
            if (sb_q.size() == 0) begin
                checkOutput("rd_kind_unexpected", 1, 0);
            end else begin
                e = sb_q.pop_front();
                checkOutput($sformatf("rd_kind(%0d,%0d)", e.x, e.y), int'(bus.rd_kind), e.exp);
            end
        end
    end

    task automatic model_zero();
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                model[y][x] = 0;
    endtask

    // Reference compaction: keep non-full rows in order, packed against the floor.
    function automatic int model_clear();
        int nm [H][W];
        int k;
        int dst;
        bit full;
        k = 0;
        dst = H - 1;
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                nm[y][x] = 0;
        for (int y = H - 1; y >= 0; y--) begin
            full = 1'b1;
            for (int x = 0; x < W; x++)
                if (model[y][x] == 0) full = 1'b0;
            if (full) begin
                k++;
            end else begin
                for (int x = 0; x < W; x++) nm[dst][x] = model[y][x];
                dst--;
            end
        end
        model = nm;
        return k;
    endfunction

    task automatic applyStimulus(input vec_t v, input logic cs, input logic cb, input bit track);
        rd_exp_t e;
        @(negedge clk);
        bus.wr_en       = v.we;
        bus.wr_x        = 5'(v.wx);
        bus.wr_y        = 5'(v.wy);
        bus.wr_kind     = KIND_W'(v.wk);
        bus.rd_x        = 5'(v.rx);
        bus.rd_y        = 5'(v.ry);
        bus.clear_start = cs;
        bus.clear_board = cb;
        rd_req          = v.re;
        if (v.re) begin
            e.exp = v.exp;
            e.x   = v.rx;
            e.y   = v.ry;
            sb_q.push_back(e);
        end
        if (track && cb) model_zero();
        else if (track && v.we && v.wx < W && v.wy < H) model[v.wy][v.wx] = v.wk;
        @(posedge clk);
        #2;
        bus.wr_en       = 1'b0;
        bus.clear_start = 1'b0;
        bus.clear_board = 1'b0;
        rd_req          = 1'b0;
    endtask

    task automatic write_cell(input int x, input int y, input int k, input logic cs);
        vec_t v;
        v = '{1'b1, x, y, k, 1'b0, 0, 0, 0};
        applyStimulus(v, cs, 1'b0, 1'b1);
    endtask

    task automatic read_board_check();
        vec_t v;
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) begin
                v = '{1'b0, 0, 0, 0, 1'b1, x, y, model[y][x]};
                applyStimulus(v, 1'b0, 1'b0, 1'b1);
            end
    endtask

    // Entered just after the accepting edge (edge 1); optionally injects a write plus restart mid-scan.
    task automatic run_scan(input string name, input int exp_edges, input int exp_lines, input int inject_at);
        int edges;
        int busy_cycles;
        bit seen;
        edges = 1;
        seen = 1'b0;
        busy_cycles = bus.busy ? 1 : 0;
        checkOutput({name, "_lines_on_entry"}, int'(bus.lines_cleared), 0);
        while (!seen && edges < 100) begin
            if (edges == inject_at) begin
                bus.wr_en       = 1'b1;
                bus.wr_x        = 5'd0;
                bus.wr_y        = 5'd0;
                bus.wr_kind     = KIND_W'(7);
                bus.clear_start = 1'b1;
            end
            @(posedge clk);
            #1;
            bus.wr_en       = 1'b0;
            bus.clear_start = 1'b0;
            edges++;
            if (bus.busy) busy_cycles++;
            if (bus.clear_done) seen = 1'b1;
        end
        checkOutput({name, "_done_seen"}, int'(seen), 1);
        checkOutput({name, "_done_edge"}, edges, exp_edges);
        checkOutput({name, "_busy_cycles"}, busy_cycles, exp_edges);
        checkOutput({name, "_lines"}, int'(bus.lines_cleared), exp_lines);
        @(posedge clk);
        #1;
        checkOutput({name, "_done_pulse_end"}, int'(bus.clear_done), 0);
        checkOutput({name, "_busy_end"}, int'(bus.busy), 0);
        checkOutput({name, "_lines_hold"}, int'(bus.lines_cleared), exp_lines);
    endtask

    initial begin
        vec_t v;
        int   k;
        int   pulses;
        int   busy_seen;

        bus.rd_x = '0; bus.rd_y = '0; bus.wr_en = 1'b0; bus.wr_x = '0; bus.wr_y = '0;
        bus.wr_kind = '0; bus.clear_start = 1'b0; bus.clear_board = 1'b0;
        model_zero();

        vecs[0]  = '{1'b1,  4,  7, 3, 1'b0,  0,  0, 0};
        vecs[1]  = '{1'b0,  0,  0, 0, 1'b1,  4,  7, 3};
        vecs[2]  = '{1'b1, 12,  5, 7, 1'b0,  0,  0, 0};
        vecs[3]  = '{1'b1, 16,  5, 7, 1'b0,  0,  0, 0};
        vecs[4]  = '{1'b0,  0,  0, 0, 1'b1,  0,  5, 0};
        vecs[5]  = '{1'b1,  4,  7, 9, 1'b1,  4,  7, 3};
        vecs[6]  = '{1'b0,  0,  0, 0, 1'b1,  4,  7, 9};
        vecs[7]  = '{1'b1,  9, 19, 1, 1'b0,  0,  0, 0};
        vecs[8]  = '{1'b0,  0,  0, 0, 1'b1,  9, 19, 1};
        vecs[9]  = '{1'b1,  0,  0, 8, 1'b1, 10,  0, 0};
        vecs[10] = '{1'b0,  0,  0, 0, 1'b1,  0,  0, 8};
        vecs[11] = '{1'b0,  0,  0, 0, 1'b1,  0, 20, 0};
        vecs[12] = '{1'b1,  4,  7, 0, 1'b0,  0,  0, 0};
        vecs[13] = '{1'b0,  0,  0, 0, 1'b1,  4,  7, 0};

        #1 reset_n = 1'b0;
        #10;
        checkOutput("reset_rd_kind", int'(bus.rd_kind), 0);
        checkOutput("reset_busy", int'(bus.busy), 0);
        checkOutput("reset_clear_done", int'(bus.clear_done), 0);
        checkOutput("reset_lines", int'(bus.lines_cleared), 0);
        @(negedge clk);
        reset_n = 1'b1;

        $display("[TB] reading the whole board after reset");
        read_board_check();

        $display("[TB] table-driven writes and lookups");
        for (int i = 0; i < 14; i++) applyStimulus(vecs[i], 1'b0, 1'b0, 1'b1);
        read_board_check();

        v = '{1'b0, 0, 0, 0, 1'b0, 0, 0, 0};
        applyStimulus(v, 1'b0, 1'b1, 1'b1);

        $display("[TB] single line clear, last write shares the start cycle");
        for (int x = 0; x < W - 1; x++) write_cell(x, 19, 2, 1'b0);
        write_cell(0, 18, 5, 1'b0);
        write_cell(9, 19, 2, 1'b1);
        k = model_clear();
        run_scan("one_line", 22, 1, -1);
        read_board_check();

        $display("[TB] four stacked lines over a gapped row");
        for (int y = 15; y < H; y++)
            for (int x = 0; x < W; x++)
                if (!(y == 15 && x == 3) && !(y == 19 && x == 9))
                    write_cell(x, y, (y == 15) ? (x % 9) + 1 : 1 + ((x + y) % 9), 1'b0);
        write_cell(9, 19, 1 + ((9 + 19) % 9), 1'b1);
        k = model_clear();
        run_scan("four_lines", 25, 4, -1);
        read_board_check();

        $display("[TB] eight lines saturate the counter");
        write_cell(5, 11, 9, 1'b0);
        for (int y = 12; y < H; y++)
            for (int x = 0; x < W; x++)
                if (!(y == 19 && x == 9))
                    write_cell(x, y, 1 + ((x * 3 + y) % 9), 1'b0);
        write_cell(9, 19, 1 + ((27 + 19) % 9), 1'b1);
        k = model_clear();
        run_scan("eight_lines", 29, 7, -1);
        read_board_check();

        $display("[TB] clear_board in idle keeps lines_cleared");
        v = '{1'b0, 0, 0, 0, 1'b0, 0, 0, 0};
        applyStimulus(v, 1'b0, 1'b1, 1'b1);
        checkOutput("wipe_idle_lines", int'(bus.lines_cleared), 7);
        read_board_check();

        $display("[TB] write and restart while busy are dropped");
        write_cell(0, 0, 2, 1'b0);
        write_cell(3, 10, 4, 1'b0);
        write_cell(9, 19, 6, 1'b1);
        k = model_clear();
        run_scan("busy_ignore", 21, 0, 5);
        read_board_check();

        $display("[TB] clear_board mid-scan");
        for (int x = 0; x < W - 1; x++) write_cell(x, 19, 3, 1'b0);
        write_cell(9, 19, 3, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        bus.clear_board = 1'b1;
        bus.clear_start = 1'b1;
        bus.wr_en = 1'b1; bus.wr_x = 5'd1; bus.wr_y = 5'd1; bus.wr_kind = KIND_W'(6);
        @(posedge clk);
        #1;
        bus.clear_board = 1'b0; bus.clear_start = 1'b0; bus.wr_en = 1'b0;
        model_zero();
        checkOutput("wipe_scan_busy", int'(bus.busy), 0);
        checkOutput("wipe_scan_done", int'(bus.clear_done), 0);
        checkOutput("wipe_scan_lines", int'(bus.lines_cleared), 0);
        pulses = 0;
        busy_seen = 0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (bus.clear_done) pulses++;
            if (bus.busy) busy_seen++;
        end
        checkOutput("wipe_scan_no_pulse", pulses, 0);
        checkOutput("wipe_scan_no_restart", busy_seen, 0);
        read_board_check();

        $display("[TB] asynchronous reset during scan");
        write_cell(0, 19, 5, 1'b0);
        v = '{1'b0, 0, 0, 0, 1'b0, 0, 19, 0};
        applyStimulus(v, 1'b1, 1'b0, 1'b1);
        repeat (3) @(posedge clk);
        #3;
        checkOutput("pre_reset_rd_kind", int'(bus.rd_kind), 5);
        checkOutput("pre_reset_busy", int'(bus.busy), 1);
        reset_n = 1'b0;
        #1;
        checkOutput("async_reset_rd_kind", int'(bus.rd_kind), 0);
        checkOutput("async_reset_busy", int'(bus.busy), 0);
        checkOutput("async_reset_done", int'(bus.clear_done), 0);
        checkOutput("async_reset_lines", int'(bus.lines_cleared), 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        model_zero();
        v = '{1'b0, 0, 0, 0, 1'b1, 0, 19, 0};
        applyStimulus(v, 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        #2;
        checkOutput("post_reset_idle", int'(bus.busy), 0);

        checkOutput("scoreboard_drained", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/tetris_board.md
# tetris_board

Playfield store and line-clear engine for the Tetris game. It holds a 10×20 grid of 4-bit block kinds. It answers the display renderer's per-pixel cell lookups: the renderer drives cell coordinates and consumes a `kind`. It accepts cell writes from game logic when a piece locks. On request, it scans the grid, removes full rows, shifts the rows above down, and reports how many lines were cleared.

## Interface
Parameters:
- `WIDTH`, 10: playfield columns.
- `HEIGHT`, 20: playfield rows; row 0 is the top.
- `KIND_W`, 4: bits per cell. 0 means empty; 1–9 are block kinds.

Ports:
- `clk` in 1: single clock.
- `reset_n` in 1: reset is asynchronous and active-low.
- `rd_x` in 5: lookup column, driven by the renderer.
- `rd_y` in 5: lookup row, driven by the renderer.
- `rd_kind` out `KIND_W`: registered cell contents at (`rd_x`,`rd_y`).
- `wr_en` in 1: write strobe, one cell per cycle.
- `wr_x` in 5, `wr_y` in 5: write coordinate.
- `wr_kind` in `KIND_W`: value to write; 0 erases the cell.
- `clear_start` in 1: single-cycle request to run line clearing.
- `clear_board` in 1: wipes the whole grid (new game).
- `busy` out 1: high while the engine is not IDLE.
- `clear_done` out 1: single-cycle completion pulse.
- `lines_cleared` out 3: number of rows removed by the last completed run.

## Operation
- Storage is a flop array organised as `HEIGHT` rows of `WIDTH*KIND_W` bits.
- Reset state:
  - all cells are 0;
  - `rd_kind`=0, `busy`=0, `clear_done`=0, `lines_cleared`=0;
  - FSM is in IDLE, row pointer is 0, counter is 0.
- Read path:
  - `rd_kind` is registered from the array every cycle in every state.
  - An out-of-range coordinate (`rd_x`≥WIDTH or `rd_y`≥HEIGHT) returns 0.
  - During SCAN, reads return intermediate contents. This is accepted.
- Write path:
  - A write is applied only in IDLE, only when `wr_en`=1, and only when the coordinate is in range.
  - Out-of-range writes are ignored silently.
  - Writes in any other state are dropped.
- FSM states: IDLE, SCAN, DONE.
  - IDLE → SCAN on `clear_start`. On entry: row pointer `r`=HEIGHT−1, counter=0, `lines_cleared`=0.
  - SCAN, one action per cycle:
    - If row `r` is full (every cell nonzero): rows 1..r take the contents of rows 0..r−1 in the same cycle, row 0 becomes all-zero, the counter increments, and `r` stays put so the newly shifted row is re-tested.
    - Else if `r`=0: go to DONE.
    - Else: `r` decrements.
  - DONE: load `lines_cleared` with the counter (which saturates at 7), assert `clear_done` for this one cycle, then return to IDLE.
- `clear_start` is ignored while `busy`=1.
- A write and `clear_start` in the same IDLE cycle: the write lands, and the scan sees it.
- `clear_board` has the highest priority and acts in any state:
  - all cells go to 0 at the next edge;
  - the FSM returns to IDLE;
  - the counter is zeroed;
  - no `clear_done` pulse is produced;
  - `lines_cleared` is unchanged;
  - a `wr_en` or `clear_start` in the same cycle is ignored.
- `lines_cleared` holds its value until the next accepted `clear_start`.

## Timing
- Read latency is 1 cycle. Coordinates sampled at edge N appear on `rd_kind` after edge N.
- Reads are read-before-write: a read and a write to the same cell in the same cycle return the old value.
- Let k be the number of full rows removed.
  - The engine spends HEIGHT+k cycles in SCAN.
  - `clear_done`=1 in the cycle following edge HEIGHT+k+1, counted from the edge that accepted `clear_start`.
  - For k=0 and HEIGHT=20, `clear_done` is high after edge 21.
- `busy` rises after the accepting edge and falls after the DONE cycle. `busy` and `clear_done` overlap in the DONE cycle.
- Reset asserted mid-scan forces the full reset state immediately, without waiting for a clock edge.

## Structure
- Shared package `tetris_pkg` contains:
  - `BOARD_W`=10, `BOARD_H`=20, `KIND_W`=4;
  - `kind_t` (logic [3:0]), with `KIND_EMPTY`=0;
  - the `board_state_t` enum {IDLE, SCAN, DONE}.
- The display renderer imports the same `kind_t` and dimensions.
- One sub-module, `tetris_row_full`: a purely combinational full-row test (AND-reduce of per-cell nonzero) on a `WIDTH*KIND_W` row. It is instantiated once, on the row selected by `r`.

## Test plan
- Reset, then read all 200 cells → every `rd_kind` is 0. Read (10,0) and (0,20) → 0.
- Write kind 3 at (4,7); read (4,7) on the next cycle → 3. Write (12,5) → no cell changes.
- Fill row 19 with kind 2, put kind 5 at (0,18), then `clear_start`:
  - `clear_done` arrives after 22 edges;
  - `lines_cleared`=1;
  - (0,19)=5;
  - row 18 is all 0.
- Fill rows 16–19 completely, leave a gap in row 15, then `clear_start`:
  - `lines_cleared`=4, `busy` is high for 25 cycles;
  - old row 15 now sits at row 19.
- While `busy`, drive `wr_en` and `clear_start` → no cell change, no restart. Assert `clear_board` mid-SCAN → grid is all 0, FSM in IDLE, no `clear_done`.
- Assert `reset_n`=0 asynchronously between edges during SCAN → outputs are 0 immediately.
